// File: rtl/frame_tx_serializer.sv
// frame_tx_serializer: MSB-first byte serializer of wide frames toward a UART, with one-deep pending frame buffer
module frame_tx_serializer #(
  parameter int WIDTH_DIN = 18*8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int NBYTES = WIDTH_DIN / 8;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [WIDTH_DIN-1:0] sh, sh_n, pend_data, pd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pend_valid, pv_n, fd_n, ov_n, hs, last;
  assign tx_valid = state == SEND;
  assign tx_data = sh[WIDTH_DIN-1 -: 8];
  assign hs = tx_valid & tx_ready;
  assign last = hs && cnt == CW'(NBYTES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      pend_data <= '0;
      cnt <= '0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      pend_data <= pd_n;
      cnt <= cnt_n;
      pend_valid <= pv_n;
      frame_done <= fd_n;
      overflow <= ov_n;
      busy <= state_n == SEND || pv_n;
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    pd_n = pend_data;
    pv_n = pend_valid;
    fd_n = 1'b0;
    ov_n = overflow;
    if (state == IDLE) begin
      if (din_valid) begin
        sh_n = din;
        cnt_n = '0;
        state_n = SEND;
      end
    end else if (last) begin
      cnt_n = '0;
      fd_n = 1'b1;
      sh_n = pend_valid ? pend_data : din;
      state_n = (pend_valid || din_valid) ? SEND : IDLE;
      pv_n = pend_valid && din_valid;
      pd_n = (pend_valid && din_valid) ? din : pend_data;
    end else begin
      sh_n = hs ? sh << 8 : sh;
      cnt_n = hs ? cnt + CW'(1) : cnt;
      pv_n = pend_valid | din_valid;
      pd_n = (din_valid && !pend_valid) ? din : pend_data;
      ov_n = overflow | (din_valid & pend_valid);
    end
  end
endmodule

// File: tb/tb_frame_tx_serializer.sv
// tb_frame_tx_serializer: table-driven and directed self-checking bench for frame_tx_serializer
module tb_frame_tx_serializer;
  logic clk = 1'b0;
  logic rst, din_valid, tx_ready;
  logic [143:0] din;
  logic [7:0] tx_data;
  logic tx_valid, busy, frame_done, overflow;
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int stab_bad = 0;
  logic hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] rx_q[$];
  logic [143:0] fa, fb, fc;
  typedef struct {
    logic dv;
    logic rdy;
    logic [143:0] d;
    logic ev;
    logic [7:0] ed;
    logic cd;
    logic eb;
    logic ef;
    logic eo;
  } vec_t;
  vec_t tbl[21];
  frame_tx_serializer dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (!rst && frame_done) fd_cnt <= fd_cnt + 1;
    if (!rst && hold && (!tx_valid || tx_data != hold_data)) stab_bad <= stab_bad + 1;
    hold <= !rst && tx_valid && !tx_ready;
    hold_data <= tx_data;
  end
  function automatic logic [7:0] byte_of(logic [143:0] f, int i);
    return f[143-8*i -: 8];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse(input logic [143:0] f);
    din_valid = 1'b1;
    din = f;
    tick();
    din_valid = 1'b0;
    din = '0;
  endtask
  task automatic run_until_idle(input string name, input int mode);
    int k = 0;
    do begin
      tx_ready = (mode == 0) || (k % 3 == 0);
      tick();
      k++;
    end while ((busy || tx_valid) && k < 300);
    tx_ready = 1'b1;
    chk({name, "_idle"}, {30'd0, busy, tx_valid}, 0);
    tick();
  endtask
  task automatic chk_q(input string name, input int base, input logic [143:0] f0, input logic [143:0] f1, input int nf);
    int bad = -1;
    chk({name, "_len"}, rx_q.size() - base, 18 * nf);
    for (int i = 0; i < 18 * nf; i++) begin
      if (base + i < rx_q.size() && bad < 0 && rx_q[base+i] !== (i < 18 ? byte_of(f0, i) : byte_of(f1, i - 18))) bad = i;
    end
    chk({name, "_bytes_first_bad_idx"}, bad, -1);
  endtask
  initial begin
    int rb, fbase;
    fa = {"Aasdfghjkl", 64'h0};
    fb = 144'h0102030405060708090a0b0c0d0e0f101112;
    fc = {18{8'hC3}};
    tbl[0] = '{1'b1, 1'b1, fa, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 18; i++) tbl[i] = '{1'b0, 1'b1, '0, 1'b1, byte_of(fa, i - 1), 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, '0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b1, '0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    rb = rx_q.size();
    for (int r = 0; r < 21; r++) begin
      din_valid = tbl[r].dv;
      din = tbl[r].d;
      tx_ready = tbl[r].rdy;
      chk($sformatf("row%0d_tx_valid", r), tx_valid, tbl[r].ev);
      if (tbl[r].cd) chk($sformatf("row%0d_tx_data", r), tx_data, tbl[r].ed);
      chk($sformatf("row%0d_busy", r), busy, tbl[r].eb);
      chk($sformatf("row%0d_frame_done", r), frame_done, tbl[r].ef);
      chk($sformatf("row%0d_overflow", r), overflow, tbl[r].eo);
      tick();
    end
    din_valid = 1'b0;
    chk("single_first_byte", rx_q.size() > rb ? rx_q[rb] : 8'hxx, 8'h41);
    chk("single_second_byte", rx_q.size() > rb + 1 ? rx_q[rb+1] : 8'hxx, 8'h61);
    chk_q("single", rb, fa, fa, 1);
    rb = rx_q.size();
    fbase = fd_cnt;
    pulse(fa);
    run_until_idle("backpressure", 1);
    chk_q("backpressure", rb, fa, fa, 1);
    chk("backpressure_done_cnt", fd_cnt - fbase, 1);
    rb = rx_q.size();
    fbase = fd_cnt;
    pulse(fa);
    repeat (4) tick();
    pulse(fb);
    repeat (13) tick();
    chk("queue_boundary_valid", tx_valid, 1);
    chk("queue_boundary_data", tx_data, 8'h01);
    chk("queue_boundary_done", frame_done, 1);
    chk("queue_overflow", overflow, 0);
    run_until_idle("queue", 0);
    chk_q("queue", rb, fa, fb, 2);
    chk("queue_done_cnt", fd_cnt - fbase, 2);
    rb = rx_q.size();
    fbase = fd_cnt;
    pulse(fa);
    repeat (2) tick();
    pulse(fb);
    repeat (3) tick();
    chk("ovf_before_drop", overflow, 0);
    pulse(fc);
    chk("ovf_set", overflow, 1);
    run_until_idle("ovf", 0);
    chk_q("ovf", rb, fa, fb, 2);
    chk("ovf_done_cnt", fd_cnt - fbase, 2);
    repeat (5) tick();
    chk("ovf_sticky", overflow, 1);
    pulse(fa);
    tick();
    pulse(fb);
    repeat (4) tick();
    chk("abort_pre_valid", tx_valid, 1);
    chk("abort_pre_data", tx_data, 8'h68);
    rst = 1'b1;
    din_valid = 1'b1;
    din = fc;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    din = '0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_frame_done", frame_done, 0);
    tick();
    fbase = fd_cnt;
    repeat (20) tick();
    chk("abort_no_done", fd_cnt - fbase, 0);
    chk("abort_stays_idle", tx_valid, 0);
    rb = rx_q.size();
    pulse(fc);
    run_until_idle("abort_fresh", 0);
    chk_q("abort_fresh", rb, fc, fc, 1);
    chk("abort_fresh_done_cnt", fd_cnt - fbase, 1);
    rb = rx_q.size();
    fbase = fd_cnt;
    pulse(fa);
    repeat (17) tick();
    chk("coinc_last_valid", tx_valid, 1);
    chk("coinc_last_data", tx_data, 8'h00);
    pulse(fb);
    chk("coinc_valid", tx_valid, 1);
    chk("coinc_data", tx_data, 8'h01);
    chk("coinc_done", frame_done, 1);
    chk("coinc_overflow", overflow, 0);
    run_until_idle("coinc", 0);
    chk_q("coinc", rb, fa, fb, 2);
    chk("coinc_done_cnt", fd_cnt - fbase, 2);
    chk("hold_stable", stab_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
